// File: rtl/uart_parity_unit.sv
// UART parity engine: registered TX parity generation from a parallel word and
// bit-serial RX parity checking against a configuration latched at frame start.
module uart_parity_unit #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  par_en,
   input  logic [1:0]            PAR_TYP,
   input  logic [LEN_WIDTH-1:0]  data_len,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  par_bit,
   output logic                  par_valid,
   input  logic                  rx_start,
   input  logic                  rx_bit_vld,
   input  logic                  rx_bit,
   output logic                  chk_done,
   output logic                  par_err
);

   typedef enum logic [1:0] {
      RX_IDLE = 2'b00,
      RX_DATA = 2'b01,
      RX_PAR  = 2'b10
   } rx_state_t;

   localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(DATA_WIDTH);

   // A length of zero or beyond the word width means "use the full word".
   function automatic logic [LEN_WIDTH-1:0] norm_len(input logic [LEN_WIDTH-1:0] l);
      if ((l == '0) || (l > MAX_LEN)) return MAX_LEN;
      return l;
   endfunction

   function automatic logic exp_par(input logic x, input logic [1:0] t);
      case (t)
         2'b00:   return x;
         2'b01:   return ~x;
         2'b10:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   logic [LEN_WIDTH-1:0]  tx_len;
   logic [DATA_WIDTH-1:0] tx_mask;
   logic                  par_bit_q, par_bit_d;
   logic                  par_valid_q, par_valid_d;

   rx_state_t             state_q, state_d;
   logic                  acc_q, acc_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [1:0]            typ_q, typ_d;
   logic                  en_q, en_d;
   logic                  chk_done_q, chk_done_d;
   logic                  par_err_q, par_err_d;
   logic [LEN_WIDTH-1:0]  cnt_inc;

   always_comb begin
      tx_len = norm_len(data_len);
      for (int i = 0; i < DATA_WIDTH; i++) begin
         tx_mask[i] = (LEN_WIDTH'(i) < tx_len);
      end
   end

   always_comb begin
      par_bit_d   = par_bit_q;
      par_valid_d = par_valid_q;
      if (load) begin
         if (par_en) begin
            par_bit_d   = exp_par(^(P_DATA & tx_mask), PAR_TYP);
            par_valid_d = 1'b1;
         end else begin
            par_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         par_bit_q   <= 1'b0;
         par_valid_q <= 1'b0;
      end else begin
         par_bit_q   <= par_bit_d;
         par_valid_q <= par_valid_d;
      end
   end

   assign cnt_inc = cnt_q + LEN_WIDTH'(1);

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      typ_d      = typ_q;
      en_d       = en_q;
      chk_done_d = 1'b0;
      par_err_d  = par_err_q;
      // A new frame overrides whatever is in flight, including a same-cycle bit.
      if (rx_start) begin
         en_d      = par_en;
         typ_d     = PAR_TYP;
         len_d     = norm_len(data_len);
         acc_d     = 1'b0;
         cnt_d     = '0;
         par_err_d = 1'b0;
         state_d   = RX_DATA;
      end else begin
         case (state_q)
            RX_DATA: begin
               if (rx_bit_vld) begin
                  acc_d = acc_q ^ rx_bit;
                  cnt_d = cnt_inc;
                  if (cnt_inc == len_q) begin
                     if (en_q) begin
                        state_d = RX_PAR;
                     end else begin
                        chk_done_d = 1'b1;
                        state_d    = RX_IDLE;
                     end
                  end
               end
            end
            RX_PAR: begin
               if (rx_bit_vld) begin
                  par_err_d  = (rx_bit != exp_par(acc_q, typ_q));
                  chk_done_d = 1'b1;
                  state_d    = RX_IDLE;
               end
            end
            default: begin
               state_d = RX_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= RX_IDLE;
         acc_q      <= 1'b0;
         cnt_q      <= '0;
         len_q      <= MAX_LEN;
         typ_q      <= 2'b00;
         en_q       <= 1'b0;
         chk_done_q <= 1'b0;
         par_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         typ_q      <= typ_d;
         en_q       <= en_d;
         chk_done_q <= chk_done_d;
         par_err_q  <= par_err_d;
      end
   end

   assign par_bit   = par_bit_q;
   assign par_valid = par_valid_q;
   assign chk_done  = chk_done_q;
   assign par_err   = par_err_q;

endmodule
